// File: rtl/jtmx5k_pkg.sv
// Shared definitions for the MX5000 graphics ROM arbiter: default widths,
// timeout length, FSM state encoding and the tie-break grant helper.
package jtmx5k_pkg;

    localparam int JTMX5K_AW   = 18;
    localparam int JTMX5K_DW   = 16;
    localparam int JTMX5K_TOUT = 63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Selects the requester to serve: the only pending one, or on a tie
    // the one that was not served last (returns 1 for gfx2).
    function automatic logic pick_gnt(input logic pend0, input logic pend1,
                                      input logic last);
        if (pend0 && pend1) return ~last;
        return pend1;
    endfunction

endpackage

// File: rtl/jtmx5k_arb_latch.sv
// Per-requester return latch: keeps the last served address/data and a
// valid flag, and reports ok while the requester still asks for that word.
module jtmx5k_arb_latch
    import jtmx5k_pkg::*;
#(
    parameter int AW = JTMX5K_AW,
    parameter int DW = JTMX5K_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          clr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] data,
    output logic          ok
);

    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic          lat_vld;

    // Invalidate on grant, capture address/data when the slot returns a word
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_vld  <= 1'b0;
        end else if (clr) begin
            lat_vld  <= 1'b0;
        end else if (wr) begin
            lat_addr <= wr_addr;
            lat_data <= wr_data;
            lat_vld  <= 1'b1;
        end
    end

    assign data = lat_data;
    assign ok   = cs & lat_vld & (lat_addr == addr);

endmodule

// File: rtl/jtmx5k_gfx_arb.sv
// Shares the single graphics-ROM SDRAM slot between gfx1 (rq0) and gfx2
// (rq1). Requests are served round-robin; each requester sees its own latch
// through the usual cs/addr/ok handshake.
// Handshake: a requester holds cs/addr until ok is high; ok is high only
// while cs is high and addr matches the latched word. slot_cs is held
// from grant until slot_ok (or timeout); slot_ok is only honoured in WAIT.
// Build option: define JTMX5K_ARB_BYPASS_EN to wire rq0 straight to the
// slot (single-engine wiring, no arbitration FSM).
module jtmx5k_gfx_arb
    import jtmx5k_pkg::*;
#(
    parameter int AW   = JTMX5K_AW,
    parameter int DW   = JTMX5K_DW,
    parameter int TOUT = JTMX5K_TOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rq0_cs,
    input  logic [AW-1:0] rq0_addr,
    output logic [DW-1:0] rq0_data,
    output logic          rq0_ok,
    input  logic          rq1_cs,
    input  logic [AW-1:0] rq1_addr,
    output logic [DW-1:0] rq1_data,
    output logic          rq1_ok,
    output logic          slot_cs,
    output logic [AW-1:0] slot_addr,
    input  logic [DW-1:0] slot_data,
    input  logic          slot_ok,
    output logic          tout_err,
    output logic [1:0]    st_dbg
);

`ifdef JTMX5K_ARB_BYPASS_EN

    logic unused_bypass;

    assign slot_cs   = rq0_cs;
    assign slot_addr = rq0_addr;
    assign rq0_ok    = slot_ok;
    assign rq0_data  = slot_data;
    assign rq1_ok    = 1'b1;
    assign rq1_data  = '0;
    assign tout_err  = 1'b0;
    assign st_dbg    = ST_IDLE;
    assign unused_bypass = ^{clk, rst, rq1_cs, rq1_addr};

`else

    localparam logic [5:0] TOUT_M1 = 6'(TOUT - 1);

    arb_state_t state;
    logic       gnt;
    logic       last;
    logic [5:0] cnt;
    logic       pend0, pend1;
    logic       nxt_gnt;
    logic       grant;
    logic       accept;

    assign pend0   = rq0_cs & ~rq0_ok;
    assign pend1   = rq1_cs & ~rq1_ok;
    assign nxt_gnt = pick_gnt(pend0, pend1, last);
    assign grant   = (state == ST_IDLE) & (pend0 | pend1);
    assign accept  = (state == ST_WAIT) & slot_ok;
    assign st_dbg  = state;

    jtmx5k_arb_latch #(.AW(AW), .DW(DW)) u_lat0 (
        .clk     (clk),
        .rst     (rst),
        .cs      (rq0_cs),
        .addr    (rq0_addr),
        .clr     (grant & ~nxt_gnt),
        .wr      (accept & ~gnt),
        .wr_addr (slot_addr),
        .wr_data (slot_data),
        .data    (rq0_data),
        .ok      (rq0_ok)
    );

    jtmx5k_arb_latch #(.AW(AW), .DW(DW)) u_lat1 (
        .clk     (clk),
        .rst     (rst),
        .cs      (rq1_cs),
        .addr    (rq1_addr),
        .clr     (grant & nxt_gnt),
        .wr      (accept & gnt),
        .wr_addr (slot_addr),
        .wr_data (slot_data),
        .data    (rq1_data),
        .ok      (rq1_ok)
    );

    // Arbitration FSM: grant, skip the possibly stale slot_ok in ISSUE,
    // then wait for data or give up after TOUT wait cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            last      <= 1'b0;
            cnt       <= '0;
            slot_cs   <= 1'b0;
            slot_addr <= '0;
            tout_err  <= 1'b0;
        end else begin
            tout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt       <= nxt_gnt;
                        slot_addr <= nxt_gnt ? rq1_addr : rq0_addr;
                        slot_cs   <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (slot_ok) begin
                        slot_cs <= 1'b0;
                        last    <= gnt;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (cnt == TOUT_M1) begin
                            slot_cs  <= 1'b0;
                            tout_err <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    slot_cs <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_jtmx5k_gfx_arb.sv
// Directed bench for jtmx5k_gfx_arb: a vector table of single-requester
// accesses plus hand-written sequences for tie-break, hit, stale slot_ok,
// timeout and reset-in-WAIT.
module tb_jtmx5k_gfx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rq0_cs = 1'b0, rq1_cs = 1'b0;
  logic [17:0] rq0_addr = '0, rq1_addr = '0;
  logic [15:0] rq0_data, rq1_data;
  logic        rq0_ok, rq1_ok;
  logic        slot_cs;
  logic [17:0] slot_addr;
  logic [15:0] slot_data = '0;
  logic        slot_ok = 1'b0;
  logic        tout_err;
  logic [1:0]  st_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sel;
    logic [17:0] addr;
    logic [15:0] rdata;
    int          lat;
    logic [17:0] exp_slot_addr;
    logic [15:0] exp_data;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[4];

  jtmx5k_gfx_arb dut (
    .clk       (clk),
    .rst       (rst),
    .rq0_cs    (rq0_cs),
    .rq0_addr  (rq0_addr),
    .rq0_data  (rq0_data),
    .rq0_ok    (rq0_ok),
    .rq1_cs    (rq1_cs),
    .rq1_addr  (rq1_addr),
    .rq1_data  (rq1_data),
    .rq1_ok    (rq1_ok),
    .slot_cs   (slot_cs),
    .slot_addr (slot_addr),
    .slot_data (slot_data),
    .slot_ok   (slot_ok),
    .tout_err  (tout_err),
    .st_dbg    (st_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for slot_cs (bounded), check the address, answer after lat cycles
  task automatic serve(input int lat, input logic [15:0] d, input logic [17:0] exp_addr);
    int n;
    n = 0;
    while (slot_cs !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("slot_cs_rise", {31'd0, slot_cs}, 32'd1);
    check("slot_addr", {14'd0, slot_addr}, {14'd0, exp_addr});
    for (int i = 0; i < lat; i++) step();
    slot_ok   = 1'b1;
    slot_data = d;
    step();
    slot_ok   = 1'b0;
    slot_data = '0;
    check("slot_cs_fall", {31'd0, slot_cs}, 32'd0);
  endtask

  initial begin
    int   n;
    logic seen_cs;

    vecs[0] = '{1'b0, 18'h01234, 16'hBEEF, 4, 18'h01234, 16'hBEEF, 1'b1};
    vecs[1] = '{1'b1, 18'h2ABCD, 16'h1357, 1, 18'h2ABCD, 16'h1357, 1'b1};
    vecs[2] = '{1'b0, 18'h3FFFF, 16'hFFFF, 2, 18'h3FFFF, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b1, 18'h00000, 16'h0000, 6, 18'h00000, 16'h0000, 1'b1};

    // reset state
    step(); step();
    rst = 1'b0;
    check("rst_slot_cs", {31'd0, slot_cs}, 32'd0);
    check("rst_slot_addr", {14'd0, slot_addr}, 32'd0);
    check("rst_rq0_ok", {31'd0, rq0_ok}, 32'd0);
    check("rst_rq1_ok", {31'd0, rq1_ok}, 32'd0);
    check("rst_rq0_data", {16'd0, rq0_data}, 32'd0);
    check("rst_rq1_data", {16'd0, rq1_data}, 32'd0);
    check("rst_tout_err", {31'd0, tout_err}, 32'd0);
    check("rst_state", {30'd0, st_dbg}, 32'd0);

    // table of single-requester accesses
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].sel) begin
        rq1_cs = 1'b1; rq1_addr = vecs[i].addr; rq0_cs = 1'b0;
      end else begin
        rq0_cs = 1'b1; rq0_addr = vecs[i].addr; rq1_cs = 1'b0;
      end
      serve(vecs[i].lat, vecs[i].rdata, vecs[i].exp_slot_addr);
      if (vecs[i].sel) begin
        check("vec_rq1_ok", {31'd0, rq1_ok}, {31'd0, vecs[i].exp_ok});
        check("vec_rq1_data", {16'd0, rq1_data}, {16'd0, vecs[i].exp_data});
        check("vec_rq0_ok_idle", {31'd0, rq0_ok}, 32'd0);
      end else begin
        check("vec_rq0_ok", {31'd0, rq0_ok}, {31'd0, vecs[i].exp_ok});
        check("vec_rq0_data", {16'd0, rq0_data}, {16'd0, vecs[i].exp_data});
        check("vec_rq1_ok_idle", {31'd0, rq1_ok}, 32'd0);
      end
      rq0_cs = 1'b0;
      rq1_cs = 1'b0;
      step();
    end

    // hit on an already served word: ok at once, no slot access
    rq0_cs = 1'b1; rq0_addr = 18'h3FFFF;
    #1;
    check("hit_rq0_ok", {31'd0, rq0_ok}, 32'd1);
    check("hit_rq0_data", {16'd0, rq0_data}, 32'h0000FFFF);
    seen_cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (slot_cs) seen_cs = 1'b1;
    end
    check("hit_no_slot_cs", {31'd0, seen_cs}, 32'd0);
    rq0_addr = 18'h00010;
    #1;
    check("miss_rq0_ok_drop", {31'd0, rq0_ok}, 32'd0);
    serve(2, 16'hA5A5, 18'h00010);
    check("miss_rq0_ok", {31'd0, rq0_ok}, 32'd1);
    check("miss_rq0_data", {16'd0, rq0_data}, 32'h0000A5A5);
    rq0_cs = 1'b0;
    step();

    // tie after reset: gfx2 first, one idle slot cycle, then gfx1
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_state", {30'd0, st_dbg}, 32'd0);
    check("rst2_rq0_data", {16'd0, rq0_data}, 32'd0);
    rq0_cs = 1'b1; rq0_addr = 18'h11111;
    rq1_cs = 1'b1; rq1_addr = 18'h22222;
    serve(1, 16'h2222, 18'h22222);
    check("tie_rq1_ok", {31'd0, rq1_ok}, 32'd1);
    check("tie_rq1_data", {16'd0, rq1_data}, 32'h00002222);
    check("tie_rq0_wait", {31'd0, rq0_ok}, 32'd0);
    step();
    check("tie_second_cs", {31'd0, slot_cs}, 32'd1);
    serve(3, 16'h1111, 18'h11111);
    check("tie_rq0_ok", {31'd0, rq0_ok}, 32'd1);
    check("tie_rq0_data", {16'd0, rq0_data}, 32'h00001111);
    check("tie_rq1_keep", {31'd0, rq1_ok}, 32'd1);

    // slot_ok left high through IDLE/ISSUE must not be taken
    rq0_addr  = 18'h00777;
    slot_ok   = 1'b1;
    slot_data = 16'hDEAD;
    step();
    check("stale_issue_cs", {31'd0, slot_cs}, 32'd1);
    check("stale_issue_st", {30'd0, st_dbg}, 32'd1);
    step();
    check("stale_wait_st", {30'd0, st_dbg}, 32'd2);
    check("stale_rq0_ok", {31'd0, rq0_ok}, 32'd0);
    slot_ok   = 1'b0;
    slot_data = '0;
    step(); step();
    slot_ok   = 1'b1;
    slot_data = 16'h7777;
    step();
    slot_ok   = 1'b0;
    slot_data = '0;
    check("stale_rq0_ok_late", {31'd0, rq0_ok}, 32'd1);
    check("stale_rq0_data", {16'd0, rq0_data}, 32'h00007777);

    // timeout: 1 ISSUE + 63 WAIT cycles, then retry
    rq0_cs   = 1'b0;
    rq1_addr = 18'h0AAAA;
    step();
    check("tout_issue_cs", {31'd0, slot_cs}, 32'd1);
    n = 0;
    while (tout_err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("tout_cycles", n, 32'd64);
    check("tout_slot_cs", {31'd0, slot_cs}, 32'd0);
    check("tout_rq1_ok", {31'd0, rq1_ok}, 32'd0);
    step();
    check("tout_pulse_end", {31'd0, tout_err}, 32'd0);
    check("tout_retry_cs", {31'd0, slot_cs}, 32'd1);
    check("tout_retry_addr", {14'd0, slot_addr}, 32'h0000AAAA);
    step();
    check("tout_retry_wait", {30'd0, st_dbg}, 32'd2);

    // reset while in WAIT, then re-serve
    rst = 1'b1;
    step();
    check("rstw_slot_cs", {31'd0, slot_cs}, 32'd0);
    check("rstw_rq0_ok", {31'd0, rq0_ok}, 32'd0);
    check("rstw_rq1_ok", {31'd0, rq1_ok}, 32'd0);
    check("rstw_state", {30'd0, st_dbg}, 32'd0);
    rst = 1'b0;
    serve(2, 16'h4242, 18'h0AAAA);
    check("rstw_rq1_ok_after", {31'd0, rq1_ok}, 32'd1);
    check("rstw_rq1_data", {16'd0, rq1_data}, 32'h00004242);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
